// File: rtl/gps_pkg.sv
// gps_pkg: shared widths, word type and SPI state encoding for the GPS-to-MCU SPI bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gps_pkg;

    localparam int GPS_WORD_W       = 16;
    localparam int GPS_SAMPLE_W     = 2;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int SPI_BITS         = 16;

    localparam int SAMPLE_CNT_W = $clog2(SAMPLES_PER_WORD);
    localparam int BIT_CNT_W    = $clog2(SPI_BITS);

    typedef logic [GPS_WORD_W-1:0] gps_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_state_e;

endpackage

// File: rtl/gps_word_fifo.sv
// gps_word_fifo: synchronous FIFO of GPS words, FIFO_DEPTH entries (power of two, >= 2).
// Latency: a pushed word is visible at pop_dat_o the cycle after the push edge.
// Backpressure: push while full is accepted only with a simultaneous pop; pop while empty is ignored.
module gps_word_fifo
    import gps_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  gps_word_t push_dat_i,
    input  logic      pop_i,
    output gps_word_t pop_dat_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    gps_word_t     mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers make stale entries unreadable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/gps_spi_packer.sv
// gps_spi_packer: packs 2-bit GPS samples into 16-bit words and streams them out as an SPI mode-0 master.
// Latency: FIFO write one clock after the 8th strobe; MCU_SS falls 2 clocks after that write when idle.
// Backpressure: none upstream; a word arriving at a full FIFO (no pop) is dropped, OVERFLOW sticks. Macro GPS_SPI_OVF_CNT_EN enables OVF_COUNT.
module gps_spi_packer
    import gps_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       MCU_CLK_25_000,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       SAMPLE_STB,
    input  logic       GPS_I0,
    input  logic       GPS_I1,
    output logic       MCU_SCK,
    output logic       MCU_SS,
    output logic       MCU_MOSI,
    output logic       OVERFLOW,
    output logic [7:0] OVF_COUNT
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Packer
    gps_word_t                 pack_q, pack_d;
    gps_word_t                 push_dat_q, push_dat_d;
    logic [SAMPLE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                      push_vld_q, push_vld_d;

    // FIFO interface
    gps_word_t                 fifo_dat;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic                      drop;

    // SPI engine
    spi_state_e                state_q, state_d;
    gps_word_t                 sreg_q, sreg_d;
    logic                      phase_q, phase_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
    logic                      sck_q, sck_d;
    logic                      ss_q, ss_d;
    logic                      mosi_q, mosi_d;
    logic                      ovf_q, ovf_d;

    // Shift samples in oldest-first; the 8th sample hands the word to a one-entry staging register.
    always_comb begin
        pack_d     = pack_q;
        cnt_d      = cnt_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        if (!ENABLE) begin
            pack_d = '0;
            cnt_d  = '0;
        end else if (SAMPLE_STB) begin
            pack_d = {pack_q[GPS_WORD_W-GPS_SAMPLE_W-1:0], GPS_I1, GPS_I0};
            cnt_d  = cnt_q + SAMPLE_CNT_W'(1);
            if (cnt_q == SAMPLE_CNT_W'(SAMPLES_PER_WORD - 1)) begin
                push_vld_d = 1'b1;
                push_dat_d = pack_d;
            end
        end
    end

    // Packer state.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET) begin
        if (!RESET) begin
            pack_q     <= '0;
            cnt_q      <= '0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
        end else begin
            pack_q     <= pack_d;
            cnt_q      <= cnt_d;
            push_vld_q <= push_vld_d;
            push_dat_q <= push_dat_d;
        end
    end

    gps_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (MCU_CLK_25_000),
        .rst_ni     (RESET),
        .push_i     (push_vld_q),
        .push_dat_i (push_dat_q),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // A write into a full FIFO is lost unless the SPI engine pops in the same cycle.
    assign drop  = push_vld_q && fifo_full && !pop;
    assign ovf_d = ovf_q || drop;

    // SPI sequencing plus next values of the registered pins, which trail the state by one clock.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sreg_d  = fifo_dat;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                phase_d   = 1'b0;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    // SCK falls here: present the next bit.
                    sreg_d    = {sreg_q[GPS_WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(SPI_BITS - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ss_d   = !((state_q == SETUP) || (state_q == SHIFT));
        sck_d  = (state_q == SHIFT) && phase_q;
        mosi_d = ((state_q == SETUP) || (state_q == SHIFT)) ? sreg_q[GPS_WORD_W-1] : 1'b0;
    end

    // SPI state and output pins; reset idles the bus at once, abandoning any frame.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sck_q     <= sck_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            ovf_q     <= ovf_d;
        end
    end

    assign MCU_SCK  = sck_q;
    assign MCU_SS   = ss_q;
    assign MCU_MOSI = mosi_q;
    assign OVERFLOW = ovf_q;

`ifdef GPS_SPI_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    assign ovf_cnt_d = (drop && (ovf_cnt_q != 8'hFF)) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;

    // Saturating count of dropped words, cleared only by reset.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET) begin
        if (!RESET) ovf_cnt_q <= '0;
        else        ovf_cnt_q <= ovf_cnt_d;
    end

    assign OVF_COUNT = ovf_cnt_q;
`else
    assign OVF_COUNT = 8'd0;
`endif

endmodule
